// File: rtl/dmem_mmio_responder_if.sv
// dmem_mmio_responder_if: M-stage data port between the core (master) and the memory/MMIO responder (slave).
interface dmem_mmio_responder_if;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;

    modport master(output MemWriteM, ALUResultM, WriteDataM, input ReadDataM);
    modport slave(input MemWriteM, ALUResultM, WriteDataM, output ReadDataM);
endinterface

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: serves the core's data port from a word RAM or an MMIO block (console FIFO, timer, GPIO).
// Defining DMMIO_TIMER_CMP_EN adds a timer-compare register at offset 0x10 driving a sticky irq.
module dmem_mmio_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    dmem_mmio_responder_if.slave        bus,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [31:0]                 gpio_out,
    output logic                        irq
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] FULL_CNT = (FW + 1)'(FIFO_DEPTH);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0]   count;
    logic [31:0]   timer, timer_next, cmp_rd;
    logic [13:0]   reg_sel;
    logic          ovf, is_mmio, full, empty, pop, push;
    logic          wr_mmio, wr_con, wr_tmr, wr_gpio, wr_ovf;

    assign is_mmio = bus.ALUResultM[31:16] == MMIO_BASE[31:16];
    assign reg_sel = bus.ALUResultM[15:2];
    assign wr_mmio = bus.MemWriteM && is_mmio;
    assign wr_con  = wr_mmio && reg_sel == 14'd0;
    assign wr_tmr  = wr_mmio && reg_sel == 14'd1;
    assign wr_gpio = wr_mmio && reg_sel == 14'd2;
    assign wr_ovf  = wr_mmio && reg_sel == 14'd3;

    assign empty    = count == '0;
    assign full     = count == FULL_CNT;
    assign tx_valid = !empty;
    assign pop      = tx_valid && tx_ready;
    // a full FIFO still takes a byte when the head leaves on the same edge
    assign push     = wr_con && (!full || pop);
    assign tx_data  = tx_valid ? fifo[rd_ptr] : 8'h00;

    assign timer_next = wr_tmr ? bus.WriteDataM : timer + 32'd1;

    // load data is combinational; RAM returns pre-write contents during a store
    always_comb begin
        bus.ReadDataM = mem[bus.ALUResultM[AW+1:2]];
        if (is_mmio)
            bus.ReadDataM = reg_sel == 14'd0 ? {16'h0, 8'(count), 4'h0, ovf, 1'b0, full, empty}
                          : reg_sel == 14'd1 ? timer
                          : reg_sel == 14'd2 ? gpio_out
                          : reg_sel == 14'd4 ? cmp_rd
                          : 32'h0;
    end

    // RAM stores; contents deliberately survive reset
    always_ff @(posedge clk)
        if (bus.MemWriteM && !is_mmio) mem[bus.ALUResultM[AW+1:2]] <= bus.WriteDataM;

    // FIFO payload storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= bus.WriteDataM[7:0];

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FW'(1);
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            count <= count + (FW + 1)'(push) - (FW + 1)'(pop);
            ovf   <= wr_ovf ? 1'b0 : (ovf || (wr_con && full && !pop));
        end

    // free-running timer (a load replaces the increment) and GPIO register
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            timer    <= '0;
            gpio_out <= '0;
        end else begin
            timer <= timer_next;
            if (wr_gpio) gpio_out <= bus.WriteDataM;
        end

`ifdef DMMIO_TIMER_CMP_EN
    logic [31:0] cmp;
    logic        wr_cmp;

    assign wr_cmp = wr_mmio && reg_sel == 14'd4;
    assign cmp_rd = cmp;

    // compare register; a CMP write clears irq and beats a same-edge match
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cmp <= 32'hFFFF_FFFF;
            irq <= 1'b0;
        end else if (wr_cmp) begin
            cmp <= bus.WriteDataM;
            irq <= 1'b0;
        end else if (timer_next == cmp) begin
            irq <= 1'b1;
        end
`else
    assign cmp_rd = 32'h0;
    assign irq    = 1'b0;
`endif
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder for the pipelined core's M-stage data port.
- Decodes the core's address and serves one of two targets: a word-addressed data RAM, or a small MMIO region.
- MMIO region: console TX FIFO with valid/ready drain, free-running cycle timer, GPIO output register.
- Reads are combinational, so ReadDataM is valid in the same cycle. Writes commit on the rising clock edge.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words; power of two.
- FIFO_DEPTH, 8, console FIFO entries; power of two, at least 2.
- MMIO_BASE, 32'hFFFF_0000, base address of the MMIO region; 64 KiB aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- MemWriteM  input  1  store strobe from the core.
- ALUResultM  input  32  byte address; bits [1:0] are ignored (word access only).
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data, combinational from the address.
- tx_data  output  8  console FIFO head byte.
- tx_valid  output  1  FIFO not empty.
- tx_ready  input  1  downstream sink accepts tx_data this cycle.
- gpio_out  output  32  GPIO register.
- irq  output  1  timer-compare interrupt (see Optional Feature).

Behaviour:
- Decode:
  - ALUResultM[31:16] == MMIO_BASE[31:16] → MMIO access.
  - Otherwise → RAM access.
- RAM:
  - Index = ALUResultM[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so addresses alias/wrap modulo the RAM size.
  - Write on the clock edge when MemWriteM=1.
  - Read is asynchronous; no read-during-write bypass, so a read in the write cycle returns old data.
  - RAM contents are not reset.
- MMIO map (offset = ALUResultM[15:0]):
  - 0x0 CONSOLE:
    - Write pushes WriteDataM[7:0] into the FIFO.
    - Read returns {16'b0, count[7:0], 4'b0, ovf, 1'b0, full, empty}.
  - 0x4 TIMER:
    - Read returns the 32-bit counter.
    - Write loads the counter with WriteDataM; no increment on the load edge.
  - 0x8 GPIO: read/write gpio_out.
  - 0xC OVFCLR: any write clears ovf; reads return 0.
  - All other offsets: read 0, writes ignored.
- Reads never have side effects.
- Timer:
  - Increments by 1 on every clock edge unless it is being loaded.
  - Wraps from 0xFFFF_FFFF to 0.
- FIFO:
  - tx_valid = (count != 0).
  - tx_data = head entry when tx_valid=1, 8'h00 when empty.
  - Pop occurs when tx_valid && tx_ready.
  - tx_data must remain stable while tx_valid=1 and tx_ready=0.
  - Push when not full: accepted.
  - Push when full with no pop in the same cycle: byte dropped, ovf set (sticky).
  - Push when full with a simultaneous pop: accepted, count unchanged, ovf not set.
  - Push when empty: tx_valid rises on the next cycle; no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - FIFO empty, ovf=0, timer=0, gpio_out=0.
  - tx_valid=0, tx_data=0, irq=0.
  - Reset asserted mid-drain discards all FIFO contents immediately.
- Latency:
  - Load data: 0 cycles.
  - Store visibility: the next cycle.

Optional Feature:
- Macro: DMMIO_TIMER_CMP_EN.
- Defined:
  - Adds a CMP register at offset 0x10 (R/W, reset value 0xFFFF_FFFF).
  - irq is set on the edge where the timer's new value equals CMP.
  - irq is sticky; it is cleared by any write to CMP.
  - A write to CMP and a match on the same edge: the write wins, irq=0.
- Undefined:
  - Offset 0x10 reads 0 and ignores writes.
  - irq is tied to 0.

Test Plan:
- RAM store/load and alias (DEPTH_WORDS=256):
  - Store 0xDEADBEEF at address 0x0000_0010 → load of 0x10 returns 0xDEADBEEF.
  - Load of 0x0000_0410 also returns 0xDEADBEEF (alias).
  - Load of 0x14 returns its own unwritten contents.
- Console fill and drain:
  - With tx_ready=0, push 'A'..'H' (8 bytes), then push 'I' → 'I' dropped; status reads count=8, full=1, ovf=1.
  - Raise tx_ready → tx_data sequence 0x41..0x48 over 8 cycles, then tx_valid=0.
  - Write OVFCLR → ovf=0.
- Full with simultaneous pop: FIFO full, tx_ready=1, push 0x5A → count stays 8, ovf=0, 0x5A emerges last.
- Timer:
  - Write TIMER=0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on the following three cycles.
  - GPIO write 0x0000_00A5 → gpio_out=0xA5 on the next cycle.
- Reset mid-operation:
  - With 3 bytes queued, gpio=0x1, timer=500, assert reset for 1 cycle → tx_valid=0, gpio_out=0, TIMER reads 0 then counts up.
  - RAM word written before reset still reads back unchanged.
- DMMIO_TIMER_CMP_EN:
  - Set CMP=20, TIMER=10 → irq rises when the timer reaches 20 and stays high.
  - Write CMP=100 → irq=0.
  - Build without the macro → irq always 0.
